memio_responder: RTL

- Responder end of the CPU memory/IO request interface driven by the instruction decoder: MemRead, MemWrite, IORead, IOWrite, Memory_sign and Memory_data_width.
- Serves requests against a word-wide synchronous single-port data RAM (1-cycle read latency) and a handshaked IO bus in the 0xFFFFFC00–0xFFFFFFFF window.
- Does read-modify-write for sb/sh, lane extraction plus sign/zero extension for lb/lbu/lh/lhu, and alignment checking.
- Stalls the pipeline until each access completes.

---
 rtl/memio_pkg.sv | 16 +
 rtl/memio_lane_align.sv | 38 +++
 rtl/memio_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/memio_pkg.sv
// Shared encodings for the memory/IO responder: access widths, error codes, IO window, FSM states.
package memio_pkg;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b11;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_ADEL = 2'b01;
  localparam logic [1:0] E_ADES = 2'b10;
  localparam logic [1:0] E_BUS  = 2'b11;

  // addr[31:10] of every IO-mapped location (0xFFFFFC00-0xFFFFFFFF)
  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, IO, DONE} state_t;
endpackage

// File: rtl/memio_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module memio_lane_align
  import memio_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = word[{addr, 3'b000} +: 8];
    half_v   = word[{addr[1], 4'b0000} +: 16];
    load_val = word;
    merged   = wdata;
    case (width)
      W_BYTE: begin
        load_val = {{24{sign & byte_v[7]}}, byte_v};
        merged   = word;
        merged[{addr, 3'b000} +: 8] = wdata[7:0];
      end
      W_HALF: begin
        load_val = {{16{sign & half_v[15]}}, half_v};
        merged   = word;
        merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end
endmodule

// File: rtl/memio_responder.sv
// CPU memory/IO request responder: sync data RAM with sub-word RMW, handshaked IO window, stall until done.
// Optional MEMIO_TIMEOUT_EN aborts an IO access after IO_TIMEOUT cycles without io_ready.
module memio_responder
  import memio_pkg::*;
#(
  parameter int RAM_AW     = 14,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IORead,
  input  logic              IOWrite,
  input  logic              Memory_sign,
  input  logic [1:0]        Memory_data_width,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic [1:0]        err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [9:0]        io_addr,
  output logic              io_rd,
  output logic              io_wr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ready
);
  if (IO_TIMEOUT < 1) begin : g_bad_cfg
    $error("IO_TIMEOUT must be at least 1");
  end

  state_t state, state_nx;

  logic [RAM_AW-1:0] ram_word_q;
  logic [9:0]        io_addr_q;
  logic [1:0]        lane_q, width_q;
  logic              sign_q, io_rd_q, io_wr_q;
  logic [31:0]       wdata_q;

  logic [2:0]  n_req;
  logic        any_req, req_illegal, req_misal, timeout;
  logic [1:0]  req_err;
  logic [31:0] align_word, load_val, merged;

  assign n_req   = {2'b00, MemRead} + {2'b00, MemWrite} + {2'b00, IORead} + {2'b00, IOWrite};
  assign any_req = (n_req != 3'd0);

  // IO strobes aimed outside the IO window are treated as illegal, like a bad width
  assign req_illegal = (n_req > 3'd1) || (Memory_data_width == 2'b10) ||
                       ((IORead | IOWrite) && (addr[31:10] != IO_BASE_HI));
  assign req_misal   = ((Memory_data_width == W_HALF) && addr[0]) ||
                       ((Memory_data_width == W_WORD) && (addr[1:0] != 2'b00));
  assign req_err     = req_illegal ? E_BUS :
                       req_misal   ? ((MemRead | IORead) ? E_ADEL : E_ADES) : E_NONE;

`ifdef MEMIO_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            tmo_cnt <= '0;
    else if (state != IO) tmo_cnt <= '0;
    else                  tmo_cnt <= tmo_cnt + 16'd1;
  end
  assign timeout = (state == IO) && (tmo_cnt == 16'(IO_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign align_word = (state == IO) ? io_rdata : ram_rdata;

  memio_lane_align u_align (
    .word     (align_word),
    .addr     (lane_q),
    .width    (width_q),
    .sign     (sign_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (req_err != E_NONE) state_nx = DONE;
          else if (MemRead)      state_nx = RD;
          else if (MemWrite)     state_nx = (Memory_data_width == W_WORD) ? WR : RMW_RD;
          else                   state_nx = IO;
        end
      end
      RD:      state_nx = DONE;
      WR:      state_nx = DONE;
      RMW_RD:  state_nx = RMW_WR;
      RMW_WR:  state_nx = DONE;
      IO:      if (io_ready || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata      <= '0;
      err        <= E_NONE;
      ram_wdata  <= '0;
      io_wdata   <= '0;
      ram_word_q <= '0;
      io_addr_q  <= '0;
      lane_q     <= '0;
      width_q    <= W_WORD;
      sign_q     <= 1'b0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          rdata      <= '0;
          err        <= req_err;
          ram_word_q <= addr[RAM_AW+1:2];
          io_addr_q  <= addr[9:0];
          lane_q     <= addr[1:0];
          width_q    <= Memory_data_width;
          sign_q     <= Memory_sign;
          io_rd_q    <= IORead;
          io_wr_q    <= IOWrite;
          wdata_q    <= wdata;
          if (state_nx == WR) ram_wdata <= wdata;
          if (state_nx == IO) io_wdata  <= wdata;
        end
        RD:     rdata     <= load_val;
        RMW_RD: ram_wdata <= merged;
        IO: begin
          if (io_ready) begin
            if (io_rd_q) rdata <= load_val;
          end else if (timeout) begin
            err <= E_BUS;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall    = ((state == IDLE) && any_req) || ((state != IDLE) && (state != DONE));
  assign ram_addr = (state == IDLE) ? addr[RAM_AW+1:2] : ram_word_q;
  assign ram_we   = (state == WR) || (state == RMW_WR);
  assign io_addr  = io_addr_q;
  assign io_rd    = (state == IO) && io_rd_q;
  assign io_wr    = (state == IO) && io_wr_q;
endmodule
